// File: rtl/cmult_rr_sched.sv
// rtl/cmult_rr_sched.sv - round-robin scheduler sharing one saturating Q24.8 x Q24.8 -> Q8.8 multiplier
module cmult_rr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int FRACT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_p,
  output logic                    rsp_ovf,
  output logic                    rsp_unf,
  output logic                    busy,
  input  logic                    cnt_clr,
  output logic [15:0]             ovf_cnt,
  output logic [15:0]             unf_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic signed [63:0] P_MAX = 64'sd32767;
  localparam logic signed [63:0] P_MIN = -64'sd32768;

  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 grant_any;
  logic [IW-1:0]        grant_idx;
  int                   arb_j;

  logic                 s1_v_q, s1_v_d;
  logic [31:0]          s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IW-1:0]        s1_id_q, s1_id_d;
  logic                 s2_v_q, s2_v_d;
  logic signed [63:0]   s2_prod_q, s2_prod_d;
  logic [IW-1:0]        s2_id_q, s2_id_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_p_q, rsp_p_d;
  logic                 rsp_ovf_q, rsp_ovf_d, rsp_unf_q, rsp_unf_d;
  logic [15:0]          ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;

  logic signed [63:0]   p_raw;
  logic [15:0]          cap_p;
  logic                 cap_ovf, cap_unf;
  logic                 strobe;

  // Round-robin search from ptr upward; reset and en both gate every grant
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_j     = 0;
    if (en && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        arb_j = (int'(ptr_q) + k) % NUM_REQ;
        if (!grant_any && req_valid[arb_j]) begin
          grant_any = 1'b1;
          grant_idx = IW'(arb_j);
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Next-state for pointer, three pipeline stages and event counters
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IW'(1);
    end

    s1_v_d  = grant_any;
    s1_a_d  = grant_any ? req_a[int'(grant_idx)*32 +: 32] : s1_a_q;
    s1_b_d  = grant_any ? req_b[int'(grant_idx)*32 +: 32] : s1_b_q;
    s1_id_d = grant_any ? grant_idx : s1_id_q;

    s2_v_d    = s1_v_q;
    s2_prod_d = {{32{s1_a_q[31]}}, s1_a_q} * {{32{s1_b_q[31]}}, s1_b_q};
    s2_id_d   = s1_id_q;

    // Arithmetic shift floors toward -inf, then clamp into Q8.8
    p_raw   = s2_prod_q >>> FRACT_BITS;
    cap_ovf = 1'b0;
    cap_unf = 1'b0;
    cap_p   = p_raw[15:0];
    if (p_raw > P_MAX) begin
      cap_p   = 16'h7FFF;
      cap_ovf = 1'b1;
    end else if (p_raw < P_MIN) begin
      cap_p   = 16'h8000;
      cap_unf = 1'b1;
    end

    rsp_valid_d = '0;
    if (s2_v_q) rsp_valid_d[s2_id_q] = 1'b1;
    rsp_p_d   = s2_v_q ? cap_p   : rsp_p_q;
    rsp_ovf_d = s2_v_q ? cap_ovf : rsp_ovf_q;
    rsp_unf_d = s2_v_q ? cap_unf : rsp_unf_q;

    // Counters see the strobe while it is presented; clear has priority
    strobe    = |rsp_valid_q;
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (strobe && rsp_ovf_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
      if (strobe && rsp_unf_q && unf_cnt_q != 16'hFFFF) unf_cnt_d = unf_cnt_q + 16'd1;
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_prod_q   <= '0;
      s2_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      s2_v_q      <= s2_v_d;
      s2_prod_q   <= s2_prod_d;
      s2_id_q     <= s2_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_unf   = rsp_unf_q;
  assign busy      = s1_v_q | s2_v_q | (|rsp_valid_q);
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

endmodule

// File: tb/tb_cmult_rr_sched.sv
// tb/tb_cmult_rr_sched.sv - randomized self-checking bench for cmult_rr_sched
module tb_cmult_rr_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           cnt_clr = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_p;
  logic           rsp_ovf, rsp_unf, busy;
  logic [15:0]    ovf_cnt, unf_cnt;

  always #5 clk = ~clk;

  cmult_rr_sched #(.NUM_REQ(N), .FRACT_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf),
    .busy(busy), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [15:0] p;
    logic        ovf;
    logic        unf;
  } rsp_t;

  rsp_t        q[$];
  int          mptr = 0;
  int          cyc = 0;
  int          xfer_id = -1;
  logic [15:0] m_ovf_cnt = '0, m_unf_cnt = '0, m_p = '0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [15:0] seen_p = '0;
  logic        seen_ovf = 1'b0, seen_unf = 1'b0;
  int          seen_id = -1;

  function automatic rsp_t model_mult(input logic [31:0] a, input logic [31:0] b, input int id, input int due);
    rsp_t   r;
    longint pa, pb, prod, raw;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    prod = pa * pb;
    raw  = prod >>> 8;
    r.due = due;
    r.id  = id;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (raw > 32767) begin
      r.p = 16'h7FFF; r.ovf = 1'b1;
    end else if (raw < -32768) begin
      r.p = 16'h8000; r.unf = 1'b1;
    end else begin
      r.p = raw[15:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom % 4)
      0:       return v;
      1:       return {{20{v[11]}}, v[11:0]};
      2:       return {{16{v[15]}}, v[15:0]};
      default: return {{8{v[23]}}, v[23:0]};
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  task automatic model_reset();
    q.delete();
    mptr = 0;
    m_p = '0; m_ovf = 1'b0; m_unf = 1'b0;
    m_ovf_cnt = '0; m_unf_cnt = '0;
  endtask

  // One clock cycle: compare at negedge, advance the model, return at posedge+1
  task automatic step();
    logic [N-1:0] exp_ready, exp_v;
    int           g;
    rsp_t         e;
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (en && rst_n) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, q.size() != 0);
    exp_v = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_v[e.id] = 1'b1;
      m_p = e.p; m_ovf = e.ovf; m_unf = e.unf;
    end
    check("rsp_valid", rsp_valid, exp_v);
    check("rsp_p", rsp_p, m_p);
    check("rsp_ovf", rsp_ovf, m_ovf);
    check("rsp_unf", rsp_unf, m_unf);
    check("ovf_cnt", ovf_cnt, m_ovf_cnt);
    check("unf_cnt", unf_cnt, m_unf_cnt);
    if (rsp_valid != '0) begin
      seen_p = rsp_p; seen_ovf = rsp_ovf; seen_unf = rsp_unf;
      seen_id = -1;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) seen_id = i;
    end
    if (!rst_n || cnt_clr) begin
      m_ovf_cnt = '0; m_unf_cnt = '0;
    end else if (exp_v != '0) begin
      if (m_ovf && m_ovf_cnt != 16'hFFFF) m_ovf_cnt = m_ovf_cnt + 16'd1;
      if (m_unf && m_unf_cnt != 16'hFFFF) m_unf_cnt = m_unf_cnt + 16'd1;
    end
    xfer_id = -1;
    if (g >= 0) begin
      xfer_id = g;
      q.push_back(model_mult(req_a[g*32 +: 32], req_b[g*32 +: 32], g, cyc + 3));
      mptr = (g + 1) % N;
    end
    if (!rst_n) model_reset();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input int id, input logic [31:0] a, input logic [31:0] b);
    set_req(id, 1'b1, a, b);
    step();
    check("one_op_xfer", xfer_id, id);
    set_req(id, 1'b0, '0, '0);
    repeat (4) step();
  endtask

  logic [N-1:0] pend;
  int           prev;

  initial begin
    // Reset: grants gated off even with requests pending
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    req_valid = '1;
    step();
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // Directed single op, saturation and rounding
    one_op(0, 32'h0000_0180, 32'h0000_0200);
    check("single_p", seen_p, 16'h0300);
    check("single_id", seen_id, 0);
    check("single_flags", {seen_ovf, seen_unf}, 2'b00);
    one_op(1, 32'h0000_C800, 32'h0000_0100);
    check("sat_hi_p", seen_p, 16'h7FFF);
    check("sat_hi_ovf", seen_ovf, 1'b1);
    check("sat_hi_cnt", ovf_cnt, 16'd1);
    one_op(1, 32'hFFFF_3800, 32'h0000_0100);
    check("sat_lo_p", seen_p, 16'h8000);
    check("sat_lo_unf", seen_unf, 1'b1);
    check("sat_lo_cnt", unf_cnt, 16'd1);
    one_op(2, 32'hFFFF_FFFF, 32'h0000_0080);
    check("floor_neg", seen_p, 16'hFFFF);
    one_op(3, 32'h0000_0080, 32'h0000_0080);
    check("quarter", seen_p, 16'h0040);

    // Fairness: every requester valid continuously
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_op(), rnd_op());
    prev = -1;
    repeat (16) begin
      step();
      if (prev >= 0) check("rr_order", xfer_id, (prev + 1) % N);
      prev = xfer_id;
      if (xfer_id >= 0) set_req(xfer_id, 1'b1, rnd_op(), rnd_op());
    end
    req_valid = '0;
    repeat (4) step();

    // Randomized traffic with en toggling, drops and clears
    pend = '0;
    repeat (3000) begin
      en = ($urandom % 8) != 0;
      cnt_clr = ($urandom % 64) == 0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom % 2 == 1) begin
            pend[i] = 1'b1;
            set_req(i, 1'b1, rnd_op(), rnd_op());
          end
        end else if ($urandom % 16 == 0) begin
          pend[i] = 1'b0;
          set_req(i, 1'b0, '0, '0);
        end
      end
      step();
      if (xfer_id >= 0) begin
        pend[xfer_id] = 1'b0;
        set_req(xfer_id, 1'b0, '0, '0);
      end
    end
    en = 1'b1;
    cnt_clr = 1'b0;
    req_valid = '0;
    repeat (4) step();

    // Reset while two ops are in flight
    set_req(0, 1'b1, 32'h0000_C800, 32'h0000_0100);
    step();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b1, 32'h0000_0180, 32'h0000_0200);
    step();
    req_valid = 4'b1100;
    rst_n = 1'b0;
    model_reset();
    repeat (4) step();
    check("rst_busy", busy, 1'b0);
    check("rst_ovf_cnt", ovf_cnt, 16'd0);
    rst_n = 1'b1;
    req_valid = 4'b1110;
    step();
    check("rst_first_grant", xfer_id, 1);
    req_valid = '0;
    repeat (4) step();

    // Counter saturation, then clear coinciding with an overflow strobe
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h0000_C800, 32'h0000_0100);
    repeat (65545) step();
    req_valid = '0;
    repeat (4) step();
    check("ovf_sat", ovf_cnt, 16'hFFFF);
    set_req(0, 1'b1, 32'h0000_C800, 32'h0000_0100);
    step();
    set_req(0, 1'b0, '0, '0);
    repeat (2) step();
    cnt_clr = 1'b1;
    step();
    check("clr_strobe_ovf", seen_ovf, 1'b1);
    cnt_clr = 1'b0;
    step();
    check("clr_wins", ovf_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
